// File: rtl/core_arf_scoreboard.sv
// rtl/core_arf_scoreboard.sv - register busy scoreboard and in-order issue grant for a 16-entry register file
// Optional writeback bypass into the hazard check: define CORE_SB_BYPASS_EN.
module core_arf_scoreboard #(
  parameter int ISSUE = 2,
  parameter int WB    = 2
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic               flush_i,
  input  logic [ISSUE-1:0]   iss_valid_i,
  output logic [ISSUE-1:0]   iss_ready_o,
  input  logic [ISSUE-1:0]   iss_sa_use_i,
  input  logic [ISSUE-1:0]   iss_sb_use_i,
  input  logic [4*ISSUE-1:0] iss_sa_i,
  input  logic [4*ISSUE-1:0] iss_sb_i,
  input  logic [ISSUE-1:0]   iss_d_use_i,
  input  logic [4*ISSUE-1:0] iss_d_i,
  input  logic [WB-1:0]      wb_en_i,
  input  logic [4*WB-1:0]    wb_addr_i,
  output logic [15:0]        busy_o,
  output logic [15:0]        stall_cnt_o,
  output logic               wb_err_o
);

  logic [15:0]      busy_q;
  logic [15:0]      stall_q;
  logic             err_q;
  logic [15:0]      wb_clr;
  logic [15:0]      hz_busy;
  logic [15:0]      set_mask;
  logic [ISSUE-1:0] hazard;
  logic [ISSUE-1:0] ready;
  logic             chain;
  logic             err_now;

  always_comb begin
    wb_clr = '0;
    for (int k = 0; k < WB; k++) begin
      if (wb_en_i[k]) wb_clr[wb_addr_i[4*k +: 4]] = 1'b1;
    end
  end

`ifdef CORE_SB_BYPASS_EN
  assign hz_busy = busy_q & ~wb_clr;
`else
  assign hz_busy = busy_q;
`endif

  // Hazards against busy state and against destinations of older valid slots.
  always_comb begin
    hazard = '0;
    ready  = '0;
    chain  = ~flush_i;
    for (int i = 0; i < ISSUE; i++) begin
      hazard[i] = (iss_sa_use_i[i] & hz_busy[iss_sa_i[4*i +: 4]]) |
                  (iss_sb_use_i[i] & hz_busy[iss_sb_i[4*i +: 4]]) |
                  (iss_d_use_i[i]  & hz_busy[iss_d_i[4*i +: 4]]);
      for (int j = 0; j < ISSUE; j++) begin
        if (j < i && iss_valid_i[j] && iss_d_use_i[j]) begin
          if ((iss_sa_use_i[i] && iss_sa_i[4*i +: 4] == iss_d_i[4*j +: 4]) ||
              (iss_sb_use_i[i] && iss_sb_i[4*i +: 4] == iss_d_i[4*j +: 4]) ||
              (iss_d_use_i[i]  && iss_d_i[4*i +: 4]  == iss_d_i[4*j +: 4]))
            hazard[i] = 1'b1;
        end
      end
      ready[i] = iss_valid_i[i] & ~hazard[i] & chain;
      chain    = ready[i];
    end
  end

  always_comb begin
    set_mask = '0;
    for (int i = 0; i < ISSUE; i++) begin
      if (ready[i] && iss_d_use_i[i]) set_mask[iss_d_i[4*i +: 4]] = 1'b1;
    end
  end

  always_comb begin
    err_now = 1'b0;
    for (int k = 0; k < WB; k++) begin
      if (wb_en_i[k] && !busy_q[wb_addr_i[4*k +: 4]] && !set_mask[wb_addr_i[4*k +: 4]])
        err_now = 1'b1;
    end
  end

  // Set wins over clear; flush wins over both and drops this cycle's error.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (flush_i) busy_q <= '0;
      else         busy_q <= (busy_q & ~wb_clr) | set_mask;
      if (err_now && !flush_i) err_q <= 1'b1;
      if (iss_valid_i[0] && !ready[0] && !flush_i && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign iss_ready_o = ready;
  assign busy_o      = busy_q;
  assign stall_cnt_o = stall_q;
  assign wb_err_o    = err_q;

endmodule

// File: tb/tb_core_arf_scoreboard.sv
// tb/tb_core_arf_scoreboard.sv - directed table-driven bench for core_arf_scoreboard
module tb_core_arf_scoreboard;

`ifdef CORE_SB_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  iss_valid_i = '0;
  logic [1:0]  iss_ready_o;
  logic [1:0]  iss_sa_use_i = '0;
  logic [1:0]  iss_sb_use_i = '0;
  logic [7:0]  iss_sa_i = '0;
  logic [7:0]  iss_sb_i = '0;
  logic [1:0]  iss_d_use_i = '0;
  logic [7:0]  iss_d_i = '0;
  logic [1:0]  wb_en_i = '0;
  logic [7:0]  wb_addr_i = '0;
  logic [15:0] busy_o;
  logic [15:0] stall_cnt_o;
  logic        wb_err_o;

  core_arf_scoreboard #(.ISSUE(2), .WB(2)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .flush_i(flush_i),
    .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o),
    .iss_sa_use_i(iss_sa_use_i), .iss_sb_use_i(iss_sb_use_i),
    .iss_sa_i(iss_sa_i), .iss_sb_i(iss_sb_i),
    .iss_d_use_i(iss_d_use_i), .iss_d_i(iss_d_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o), .wb_err_o(wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        flush;
    logic [1:0]  valid, sa_use, sb_use, d_use, wb_en;
    logic [7:0]  sa, sb, d, wb_addr;
    logic [1:0]  exp_ready;
    logic [15:0] exp_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic [1:0] v, input logic [1:0] sau,
                              input logic [7:0] sa, input logic [1:0] sbu, input logic [7:0] sb,
                              input logic [1:0] du, input logic [7:0] d,
                              input logic [1:0] we, input logic [7:0] wa,
                              input logic [1:0] r_nb, input logic [15:0] b_nb,
                              input logic [1:0] r_bp, input logic [15:0] b_bp);
    vec_t t;
    t.flush = fl; t.valid = v; t.sa_use = sau; t.sa = sa; t.sb_use = sbu; t.sb = sb;
    t.d_use = du; t.d = d; t.wb_en = we; t.wb_addr = wa;
    t.exp_ready = BP ? r_bp : r_nb;
    t.exp_busy  = BP ? b_bp : b_nb;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    flush_i = t.flush; iss_valid_i = t.valid; iss_sa_use_i = t.sa_use; iss_sa_i = t.sa;
    iss_sb_use_i = t.sb_use; iss_sb_i = t.sb; iss_d_use_i = t.d_use; iss_d_i = t.d;
    wb_en_i = t.wb_en; wb_addr_i = t.wb_addr;
  endtask

  task automatic idle();
    drive(mk(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00,
             2'b00, 16'h0, 2'b00, 16'h0));
  endtask

  initial begin
    //           fl  valid  sau    sa     sbu    sb     du     d      we     wa      r_nb   b_nb      r_bp   b_bp
    vecs[0]  = mk(0, 2'b11, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 16'h0000, 2'b11, 16'h0000);
    vecs[1]  = mk(0, 2'b11, 2'b10, 8'h30, 2'b00, 8'h00, 2'b01, 8'h03, 2'b00, 8'h00, 2'b01, 16'h0008, 2'b01, 16'h0008);
    vecs[2]  = mk(0, 2'b01, 2'b01, 8'h03, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h03, 2'b00, 16'h0000, 2'b01, 16'h0000);
    vecs[3]  = mk(0, 2'b01, 2'b01, 8'h03, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 16'h0000, 2'b01, 16'h0000);
    vecs[4]  = mk(0, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h05, 2'b00, 8'h00, 2'b01, 16'h0020, 2'b01, 16'h0020);
    vecs[5]  = mk(0, 2'b11, 2'b01, 8'h05, 2'b10, 8'h10, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 16'h0020, 2'b00, 16'h0020);
    vecs[6]  = mk(0, 2'b11, 2'b01, 8'h05, 2'b10, 8'h10, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 16'h0020, 2'b00, 16'h0020);
    vecs[7]  = mk(0, 2'b11, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 8'h57, 2'b10, 8'h50, 2'b01, 16'h0080, 2'b11, 16'h00A0);
    vecs[8]  = mk(0, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h07, 2'b01, 8'h07, 2'b00, 16'h0000, 2'b01, 16'h00A0);
    vecs[9]  = mk(0, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h07, 2'b00, 8'h00, 2'b01, 16'h0080, 2'b00, 16'h00A0);
    vecs[10] = mk(0, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 8'h77, 2'b00, 16'h0000, 2'b00, 16'h0020);
    vecs[11] = mk(1, 2'b11, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 16'h0000, 2'b00, 16'h0000);
    vecs[12] = mk(0, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h0A, 2'b00, 8'h00, 2'b01, 16'h0400, 2'b01, 16'h0400);
    vecs[13] = mk(0, 2'b01, 2'b00, 8'h00, 2'b01, 8'h0A, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 16'h0400, 2'b00, 16'h0400);
    vecs[14] = mk(0, 2'b01, 2'b00, 8'h00, 2'b01, 8'h0A, 2'b00, 8'h00, 2'b01, 8'h0A, 2'b00, 16'h0000, 2'b01, 16'h0000);

    idle();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_busy", busy_o, 16'h0000);
    check("reset_stall", stall_cnt_o, 16'h0000);
    check("reset_err", wb_err_o, 1'b0);
    @(negedge clk_i);
    arst_ni = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_ready", i), iss_ready_o, vecs[i].exp_ready);
      if (vecs[i].valid[0] && !vecs[i].exp_ready[0] && !vecs[i].flush) exp_stall++;
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_busy", i), busy_o, vecs[i].exp_busy);
      check($sformatf("v%0d_stall", i), stall_cnt_o, exp_stall);
      check($sformatf("v%0d_err", i), wb_err_o, 1'b0);
    end

    // Fill every register, then flush with live requests.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      idle();
      iss_valid_i = 2'b11; iss_d_use_i = 2'b11;
      iss_d_i = {4'(2*k+1), 4'(2*k)};
      #1;
      check($sformatf("fill%0d_ready", k), iss_ready_o, 2'b11);
    end
    @(negedge clk_i);
    idle();
    #1;
    check("fill_busy", busy_o, 16'hFFFF);
    iss_valid_i = 2'b11; flush_i = 1'b1;
    wb_en_i = 2'b01; wb_addr_i = 8'h02;
    #1;
    check("flush_ready", iss_ready_o, 2'b00);
    @(posedge clk_i);
    #1;
    check("flush_busy", busy_o, 16'h0000);
    check("flush_stall", stall_cnt_o, exp_stall);

    // Writeback to a register that is not busy.
    @(negedge clk_i);
    idle();
    wb_en_i = 2'b10; wb_addr_i = 8'h90;
    @(posedge clk_i);
    #1;
    check("err_set", wb_err_o, 1'b1);
    check("err_busy", busy_o, 16'h0000);
    @(negedge clk_i);
    idle();
    repeat (3) @(posedge clk_i);
    #1;
    check("err_sticky", wb_err_o, 1'b1);

    // Saturate the stall counter behind a busy R0.
    @(negedge clk_i);
    idle();
    iss_valid_i = 2'b01; iss_d_use_i = 2'b01; iss_d_i = 8'h00;
    @(posedge clk_i);
    #1;
    check("r0_busy", busy_o, 16'h0001);
    @(negedge clk_i);
    idle();
    iss_valid_i = 2'b11; iss_sa_use_i = 2'b01; iss_sa_i = 8'h00;
    repeat (70000) @(posedge clk_i);
    #1;
    check("stall_sat_ready", iss_ready_o, 2'b00);
    check("stall_sat", stall_cnt_o, 16'hFFFF);
    @(posedge clk_i);
    #1;
    check("stall_sat_hold", stall_cnt_o, 16'hFFFF);

    // Asynchronous reset between edges clears everything immediately.
    @(negedge clk_i);
    #2;
    arst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 16'h0000);
    check("arst_stall", stall_cnt_o, 16'h0000);
    check("arst_err", wb_err_o, 1'b0);
    check("arst_ready", iss_ready_o, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_arf_scoreboard.md
# core_arf_scoreboard

Register-hazard scoreboard and issue controller for the architectural register file (16 × 16-bit). Holds one busy bit per register. Grants in-order issue to up to ISSUE instructions per cycle only when their source and destination registers are free of pending writes. Sits between decode and the EX/MEM issue slots; writeback ports clear the busy bits.

## Interface
- ISSUE, 2, number of in-order issue slots; slot 0 is oldest.
- WB, 2, number of writeback ports; matches the register file write-port count.
- clk_i  in  1  clock.
- arst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  clear all busy bits; no grants this cycle.
- iss_valid_i  in  ISSUE  slot holds an instruction.
- iss_ready_o  out  ISSUE  slot granted this cycle; combinational.
- iss_sa_use_i / iss_sb_use_i  in  ISSUE  source A / B is read.
- iss_sa_i / iss_sb_i  in  4×ISSUE  source register addresses.
- iss_d_use_i  in  ISSUE  slot writes a destination.
- iss_d_i  in  4×ISSUE  destination register address.
- wb_en_i  in  WB  writeback completes this cycle.
- wb_addr_i  in  4×WB  writeback register address.
- busy_o  out  16  registered busy vector.
- stall_cnt_o  out  16  saturating count of cycles in which slot 0 was valid and not granted.
- wb_err_o  out  1  sticky: writeback to a non-busy register.

## Operation
- Slot i has a hazard when any of these is true:
  - a used source or the used destination hits a busy register (RAW or WAW);
  - a used source or destination equals the used destination of an older valid slot j<i in the same cycle.
- Grant is strictly in order: iss_ready_o[i] = iss_valid_i[i] & ~hazard[i] & ~flush_i & (i==0 | iss_ready_o[i-1]). A blocked slot blocks every younger slot.
- An issue fires when iss_valid_i[i] & iss_ready_o[i]. The next cycle, busy[iss_d_i[i]] is set if iss_d_use_i[i].
- A writeback with wb_en_i[k] clears busy[wb_addr_i[k]] the next cycle.
- Priority on the same register in the same cycle: flush > set > clear. A register can be re-issued as a destination in the same cycle its writeback completes only under bypass (see Configuration); the new writer's set wins.
- Two writebacks to the same address in one cycle are legal and clear once.
- A writeback to a register whose busy bit is 0 and is not being set that cycle:
  - sets wb_err_o, which holds until reset;
  - leaves the busy bit 0.
- stall_cnt_o:
  - increments when iss_valid_i[0] & ~iss_ready_o[0] & ~flush_i;
  - saturates at 16'hFFFF;
  - is cleared only by reset.
- Register 0 is tracked like every other register; there is no special case.

## Timing
- Reset values: busy_o=16'h0000, stall_cnt_o=0, wb_err_o=0. iss_ready_o follows the reset state combinationally, so it equals iss_valid_i gated by intra-group hazards.
- Reset asserted mid-operation discards all pending state immediately.
- Grant is a zero-cycle combinational path from inputs and busy state.
- Issue to busy_o visible: 1 cycle.
- Writeback to busy_o clear: 1 cycle.
- Writeback to the dependent grant:
  - with bypass: same cycle;
  - without bypass: the next cycle.
- flush_i asserted: busy_o=0 next cycle. The same-cycle issue and writeback effects are dropped.

## Configuration
- CORE_SB_BYPASS_EN defined: a busy register being cleared by any wb_en_i this cycle counts as free for the hazard check, both for sources and for destinations.
- CORE_SB_BYPASS_EN undefined: hazard checks use the registered busy bits only. A dependent instruction is granted one cycle after its producer's writeback. Simultaneous set and clear on one register cannot occur through issue.

## Test plan
- Reset, then slot0 writes R3 and slot1 reads R3 in the same cycle -> iss_ready_o=2'b01. Next cycle busy_o=16'h0008.
- With R3 busy, slot0 reads R3 and wb_en_i[0] targets R3 -> with bypass, ready[0]=1 that cycle; without bypass, ready[0]=0, then 1 the next cycle with busy_o=0.
- With R5 busy, slot0 reads R5 and slot1 is independent -> iss_ready_o=2'b00 (in-order blocking). stall_cnt_o increments by 1 per cycle.
- With bypass, writeback of R7 and a new issue writing R7 in the same cycle -> busy[7] stays 1. A later writeback of R7 clears it.
- With busy=16'hFFFF, pulse flush_i -> no grant that cycle, busy_o=0 next cycle.
- Writeback to non-busy R9 -> wb_err_o=1 and stays 1. Hold slot0 stalled for 70000 cycles -> stall_cnt_o=16'hFFFF.
